// File: rtl/shreg_deser.sv
// shreg_deser: packs a never-stalling serial bit stream into WIDTH-bit words behind a two-entry valid/ready buffer.
// Build option: define SHREG_DESER_MSB_FIRST_EN to pack MSB-first (default is LSB-first).
module shreg_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             r,
  input  logic             i,
  input  logic             i_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } buf_state_t;

  buf_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             pop;

  // word is the shift register as it will look after this edge's bit lands
  always_comb begin
`ifdef SHREG_DESER_MSB_FIRST_EN
    word = {sr[WIDTH-2:0], i};
`else
    word = {i, sr[WIDTH-1:1]};
`endif
    complete = i_valid && (cnt == LAST);
    pop      = q_valid && q_ready;
  end

  // q is the output slot itself, so every output comes straight from a flop
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state    <= EMPTY;
      cnt      <= '0;
      sr       <= '0;
      hold     <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (i_valid) begin
        sr  <= word;
        cnt <= complete ? '0 : cnt + CW'(1);
      end
      case (state)
        EMPTY: begin
          if (complete) begin
            q       <= word;
            q_valid <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (complete && pop) begin
            q <= word;
          end else if (complete) begin
            hold  <= word;
            state <= TWO;
          end else if (pop) begin
            q_valid <= 1'b0;
            state   <= EMPTY;
          end
        end
        TWO: begin
          // a pop frees a slot in time for a word finishing on the same edge
          if (pop) begin
            q <= hold;
            if (complete) begin
              hold <= word;
            end else begin
              state <= ONE;
            end
          end else if (complete) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          q_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shreg_deser.sv
// tb_shreg_deser: randomized and directed stimulus for shreg_deser, scored against a word-level queue model.
// Honours SHREG_DESER_MSB_FIRST_EN the same way the design does.
module tb_shreg_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         r = 1'b1;
  logic         i = 1'b0;
  logic         i_valid = 1'b0;
  logic         q_ready = 1'b0;
  logic [W-1:0] q;
  logic         q_valid;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_word = '0;
  int           m_n = 0;
  int           m_count = 0;
  logic         m_ovf = 1'b0;
  logic         m_complete;

  always #5 clk = ~clk;

  shreg_deser #(.WIDTH(W)) dut (
    .clk(clk),
    .r(r),
    .i(i),
    .i_valid(i_valid),
    .q(q),
    .q_valid(q_valid),
    .q_ready(q_ready),
    .overflow(overflow)
  );

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int bit_pos(input int k);
`ifdef SHREG_DESER_MSB_FIRST_EN
    return W - 1 - k;
`else
    return k;
`endif
  endfunction

  // Reference model: collect bits into a word, keep at most two words queued, count drops.
  always @(posedge clk or posedge r) begin
    if (r) begin
      m_n = 0;
      m_word = '0;
      m_count = 0;
      m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      m_complete = 1'b0;
      if (m_count > 0 && q_ready) m_count--;
      if (i_valid) begin
        m_word[bit_pos(m_n)] = i;
        m_n++;
        if (m_n == W) begin
          m_complete = 1'b1;
          m_n = 0;
        end
      end
      if (m_complete) begin
        if (m_count < 2) begin
          m_count++;
          exp_q.push_back(m_word);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // Monitor: the head of the expected queue must be on q whenever q_valid is up.
  always @(negedge clk) begin
    if (!r) begin
      check_output("q_valid", 64'(q_valid), 64'(m_count > 0));
      check_output("overflow", 64'(overflow), 64'(m_ovf));
      if (q_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_word", 64'(q), 64'hDEAD);
        end else begin
          check_output("q_data", 64'(q), 64'(exp_q[0]));
          if (q_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive_cycle(input logic b, input logic v);
    i       = b;
    i_valid = v;
    q_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [W-1:0] w, input int k_lo, input int k_hi, input bit gaps);
    for (int k = k_lo; k <= k_hi; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) drive_cycle(1'($urandom_range(0, 1)), 1'b0);
      end
      drive_cycle(w[bit_pos(k)], 1'b1);
    end
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, 1'b0);
  endtask

  task automatic async_reset();
    #3 r = 1'b1;
    #1;
    check_output("async_rst_q_valid", 64'(q_valid), 64'h0);
    check_output("async_rst_overflow", 64'(overflow), 64'h0);
    @(posedge clk);
    #2 r = 1'b0;
  endtask

  logic [7:0] raw_bits;
  logic [W-1:0] expect_0d;

  initial begin
    raw_bits = 8'b0000_1101;
`ifdef SHREG_DESER_MSB_FIRST_EN
    expect_0d = 8'hB0;
`else
    expect_0d = 8'h0D;
`endif
    repeat (3) @(posedge clk);
    #2;
    check_output("reset_q", 64'(q), 64'h0);
    check_output("reset_q_valid", 64'(q_valid), 64'h0);
    check_output("reset_overflow", 64'(overflow), 64'h0);
    r = 1'b0;

    ready_mode = 1;
    for (int k = 0; k < 8; k++) drive_cycle(raw_bits[k], 1'b1);
    check_output("bits_q", 64'(q), 64'(expect_0d));
    check_output("bits_q_valid", 64'(q_valid), 64'h1);
    idle(1);
    check_output("bits_one_cycle", 64'(q_valid), 64'h0);

    for (int k = 0; k < 8; k++) begin
      drive_cycle(raw_bits[k], 1'b1);
      if (k < 7) drive_cycle(1'b1, 1'b0);
    end
    check_output("toggle_q", 64'(q), 64'(expect_0d));
    idle(2);

    ready_mode = 0;
    apply_stimulus(8'h11, 0, W - 1, 1'b0);
    apply_stimulus(8'h22, 0, W - 1, 1'b0);
    apply_stimulus(8'h33, 0, W - 1, 1'b0);
    idle(1);
    check_output("ovf_q_held", 64'(q), 64'h11);
    check_output("ovf_sticky", 64'(overflow), 64'h1);
    ready_mode = 1;
    idle(4);
    check_output("ovf_drained", 64'(q_valid), 64'h0);
    async_reset();

    ready_mode = 0;
    apply_stimulus(8'hAA, 0, W - 1, 1'b0);
    apply_stimulus(8'h55, 0, W - 1, 1'b0);
    apply_stimulus(8'hC3, 0, W - 2, 1'b0);
    ready_mode = 1;
    apply_stimulus(8'hC3, W - 1, W - 1, 1'b0);
    ready_mode = 0;
    idle(1);
    check_output("two_pop_q", 64'(q), 64'h55);
    check_output("two_pop_no_ovf", 64'(overflow), 64'h0);
    ready_mode = 1;
    idle(1);
    check_output("two_pop_next", 64'(q), 64'hC3);
    idle(2);

    apply_stimulus(8'h00, 0, 4, 1'b0);
    async_reset();
    apply_stimulus(8'hFF, 0, W - 1, 1'b0);
    check_output("midword_reset_q", 64'(q), 64'hFF);
    idle(2);

    ready_mode = 2;
    for (int n = 0; n < 40; n++) apply_stimulus(W'($urandom), 0, W - 1, ($urandom_range(0, 1) == 1));
    ready_mode = 1;
    for (int n = 0; n < 50 && (exp_q.size() != 0 || q_valid); n++) idle(1);
    check_output("drain_empty", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
